// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants for the memory-mapped interrupt controller:
//               register window base, source count, word offsets inside the
//               window and the "no interrupt" ID value.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam logic [31:0] IRQ_BASE = 32'h0000_7f20;
    localparam int          NUM_SRC  = 6;

    // Word offsets (addr[3:2]) inside the 16-byte window
    localparam logic [1:0]  OFF_MASK = 2'd0;
    localparam logic [1:0]  OFF_PEND = 2'd1;
    localparam logic [1:0]  OFF_MODE = 2'd2;
    localparam logic [1:0]  OFF_ID   = 2'd3;

    localparam logic [31:0] ID_NONE  = 32'h8000_0000;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : One interrupt source front end: two-flop synchroniser for an
//               asynchronous request, plus a history flop for rising-edge
//               detection.
// Ports       : clk   - clock
//               reset - asynchronous active-low reset
//               irq   - raw asynchronous request
//               lvl   - synchronised level (second synchroniser stage)
//               rise  - one-cycle pulse on a synchronised 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic lvl,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= irq;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign lvl  = r_s2;
    assign rise = r_s2 & ~r_prev;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Memory-mapped interrupt controller. Synchronises NUM_SRC
//               device requests, captures them as level or edge into PEND,
//               masks them into HWInt and reports the highest-priority
//               active source through the ID register.
// Ports       : clk    - clock
//               reset  - asynchronous active-low reset
//               addr   - data-bus byte address
//               wdata  - store data
//               byteen - store byte enables (nonzero only on a store)
//               rdata  - combinational load data, 0 outside the window
//               irq_in - raw asynchronous device requests
//               HWInt  - masked pending requests to CP0
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = irq_pkg::IRQ_BASE,
    parameter int          NUM_SRC   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         byteen,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic [NUM_SRC-1:0] HWInt
);

    import irq_pkg::*;

    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_pend;

    logic [NUM_SRC-1:0] w_lvl;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_mode_chg;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_active;

    logic               w_hit;
    logic               w_wr;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_mode;
    logic               w_id_valid;
    logic [2:0]         w_idx;

    // Byte-lane and low address bits carry no information for word registers
    logic               unused_bits;
    assign unused_bits = ^{wdata[31:NUM_SRC], addr[1:0]};

    // ------------------------------------------------------------------
    // Per-source synchroniser / edge detector
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[g]),
            .lvl   (w_lvl[g]),
            .rise  (w_rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Bus decode: only full-word stores inside the window take effect
    // ------------------------------------------------------------------
    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr      = w_hit && (byteen == 4'b1111);
    assign w_wr_mask = w_wr && (addr[3:2] == OFF_MASK);
    assign w_wr_pend = w_wr && (addr[3:2] == OFF_PEND);
    assign w_wr_mode = w_wr && (addr[3:2] == OFF_MODE);

    assign w_clr      = w_wr_pend ? wdata[NUM_SRC-1:0] : '0;
    assign w_mode_chg = w_wr_mode ? (wdata[NUM_SRC-1:0] ^ r_mode) : '0;

    // ------------------------------------------------------------------
    // Pending next state. A mode change discards the bit's old capture so a
    // stale level can never masquerade as an edge (or vice versa). In edge
    // mode a fresh edge beats a simultaneous W1C so no event is lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_mode_chg[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (r_mode[i]) begin
                w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_nxt[i] = w_lvl[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_mode <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr_mask) begin
                r_mask <= wdata[NUM_SRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= wdata[NUM_SRC-1:0];
            end
        end
    end

    assign w_active = r_pend & r_mask;
    assign HWInt    = w_active;

    // ------------------------------------------------------------------
    // Priority encoder: highest index wins, so later iterations override
    // ------------------------------------------------------------------
    always_comb begin
        w_id_valid = 1'b0;
        w_idx      = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_active[i]) begin
                w_id_valid = 1'b1;
                w_idx      = i[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (addr[3:2])
                OFF_MASK: rdata = {{(32-NUM_SRC){1'b0}}, r_mask};
                OFF_PEND: rdata = {{(32-NUM_SRC){1'b0}}, r_pend};
                OFF_MODE: rdata = {{(32-NUM_SRC){1'b0}}, r_mode};
                default:  rdata = w_id_valid ? {29'd0, w_idx} : ID_NONE;
            endcase
        end
    end

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam logic [31:0] A_MASK = 32'h0000_7f20;
    localparam logic [31:0] A_PEND = 32'h0000_7f24;
    localparam logic [31:0] A_MODE = 32'h0000_7f28;
    localparam logic [31:0] A_ID   = 32'h0000_7f2c;
    localparam logic [31:0] A_OUT  = 32'h0000_7f30;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic [5:0]  irq_in;
    logic [5:0]  HWInt;

    int n_cmp;
    int n_bad;

    irq_ctrl #(
        .BASE_ADDR (32'h0000_7f20),
        .NUM_SRC   (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq_in (irq_in),
        .HWInt  (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Store is presented at a falling edge and committed on the next rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'b0000;
        addr   = 32'd0;
        wdata  = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d    = rdata;
        addr = 32'd0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        byteen = 4'b0000;
        irq_in = 6'd0;

        // Reset held: inputs toggling must not reach PEND/HWInt
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            irq_in = (k % 2 == 0) ? 6'h3F : 6'h00;
        end
        irq_in = 6'h3F;
        wait_edges(3);
        check("rst_hwint", {26'd0, HWInt}, 32'd0);
        bus_read(A_PEND, rd); check("rst_pend", rd, 32'd0);
        bus_read(A_ID,   rd); check("rst_id",   rd, 32'h8000_0000);
        @(negedge clk);
        irq_in = 6'd0;
        reset  = 1'b1;
        wait_edges(3);

        // Edge capture of a one-cycle pulse
        bus_write(A_MODE, 32'h3F, 4'hF);
        bus_write(A_MASK, 32'h04, 4'hF);
        bus_read(A_MODE, rd); check("mode_rd", rd, 32'h3F);
        bus_read(A_MASK, rd); check("mask_rd", rd, 32'h04);
        @(negedge clk); irq_in = 6'b000100;
        @(negedge clk); irq_in = 6'b000000;
        wait_edges(1);
        check("edge_e2", {26'd0, HWInt}, 32'd0);
        wait_edges(1);
        check("edge_e3", {26'd0, HWInt}, 32'h04);
        bus_read(A_ID, rd); check("edge_id", rd, 32'd2);
        bus_write(A_PEND, 32'h04, 4'hF);
        check("w1c_hwint", {26'd0, HWInt}, 32'd0);
        bus_read(A_PEND, rd); check("w1c_pend", rd, 32'd0);

        // W1C lands on the same edge that captures a new rise: set wins
        @(negedge clk); irq_in = 6'b000100;
        @(negedge clk); irq_in = 6'b000000;
        bus_write(A_PEND, 32'h04, 4'hF);
        bus_read(A_PEND, rd); check("collide", rd, 32'h04);
        bus_write(A_PEND, 32'h04, 4'hF);

        // Level mode
        bus_write(A_MODE, 32'h00, 4'hF);
        bus_write(A_MASK, 32'h01, 4'hF);
        @(negedge clk); irq_in = 6'b000001;
        wait_edges(2);
        check("lvl_e2", {26'd0, HWInt}, 32'd0);
        wait_edges(1);
        check("lvl_e3", {26'd0, HWInt}, 32'h01);
        bus_write(A_PEND, 32'h01, 4'hF);
        check("lvl_w1c", {26'd0, HWInt}, 32'h01);
        @(negedge clk); irq_in = 6'b000000;
        wait_edges(2);
        check("lvl_drop_e2", {26'd0, HWInt}, 32'h01);
        wait_edges(1);
        check("lvl_drop_e3", {26'd0, HWInt}, 32'd0);

        // Priority and masking
        bus_write(A_MODE, 32'h3F, 4'hF);
        bus_write(A_MASK, 32'h3F, 4'hF);
        @(negedge clk); irq_in = 6'b010010;
        @(negedge clk); irq_in = 6'b000000;
        wait_edges(2);
        check("pri_hwint", {26'd0, HWInt}, 32'h12);
        bus_read(A_ID, rd); check("pri_id4", rd, 32'd4);
        bus_write(A_MASK, 32'h02, 4'hF);
        bus_read(A_ID, rd); check("pri_id1", rd, 32'd1);
        check("pri_mask", {26'd0, HWInt}, 32'h02);

        // Bus rules
        bus_write(A_MASK, 32'h3F, 4'b0011);
        bus_read(A_MASK, rd); check("partial", rd, 32'h02);
        bus_write(A_OUT, 32'h00, 4'hF);
        bus_read(A_MASK, rd); check("oow_mask", rd, 32'h02);
        bus_read(A_MODE, rd); check("oow_mode", rd, 32'h3F);
        bus_read(A_OUT,  rd); check("oow_rd",   rd, 32'd0);

        // Mode flip of a pending bit discards it
        @(negedge clk); irq_in = 6'b001000;
        @(negedge clk); irq_in = 6'b000000;
        wait_edges(2);
        bus_read(A_PEND, rd); check("pend3", rd, 32'h1A);
        bus_write(A_MODE, 32'h37, 4'hF);
        bus_read(A_PEND, rd); check("mode_flip", rd, 32'h12);

        // Asynchronous reset between clock edges
        #1;
        reset = 1'b0;
        #1;
        bus_read(A_PEND, rd); check("arst_pend", rd, 32'd0);
        bus_read(A_MASK, rd); check("arst_mask", rd, 32'd0);
        check("arst_hwint", {26'd0, HWInt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_edges(1);
        bus_read(A_ID, rd); check("post_id", rd, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
